// File: rtl/fifo_pop_stage.sv
// rtl/fifo_pop_stage.sv - two-entry pop stage between an upstream fifo and a ready/valid sink
module fifo_pop_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  fifo_pop_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [1:0]            occupancy_o,
    output logic [CNT_WIDTH-1:0]  beats_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic [CNT_WIDTH-1:0]  beats_q;
    logic                  pop;
    logic                  xfer;

    // Pop depends only on local state, never on ready_i, so the upstream path stays short.
    assign pop  = ~rst_i & ~fifo_empty_i & ~flush_i & (state_q != FULL);
    assign xfer = (state_q != EMPTY) & ready_i;

    assign fifo_pop_o  = pop;
    assign valid_o     = (state_q != EMPTY);
    assign data_o      = head_q;
    assign occupancy_o = state_q;
    assign beats_o     = beats_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            if (xfer) begin
                beats_q <= beats_q + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = EMPTY;
            head_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (pop) begin
                        head_d  = fifo_data_i;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (pop && xfer) begin
                        head_d = fifo_data_i;
                    end else if (pop) begin
                        skid_d  = fifo_data_i;
                        state_d = FULL;
                    end else if (xfer) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (xfer) begin
                        head_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_pop_stage.sv
// tb/tb_fifo_pop_stage.sv - directed self-checking bench for fifo_pop_stage
module tb_fifo_pop_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        fifo_empty;
    logic [31:0] fifo_data;
    logic        fifo_pop;
    logic        valid;
    logic        ready;
    logic [31:0] data;
    logic [1:0]  occupancy;
    logic [15:0] beats;

    int passed = 0;
    int total  = 0;

    fifo_pop_stage #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .fifo_empty_i(fifo_empty),
        .fifo_data_i (fifo_data),
        .fifo_pop_o  (fifo_pop),
        .valid_o     (valid),
        .ready_i     (ready),
        .data_o      (data),
        .occupancy_o (occupancy),
        .beats_o     (beats)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Inputs change at the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic e, input logic [31:0] d, input logic r, input logic f);
        @(negedge clk);
        fifo_empty = e;
        fifo_data  = d;
        ready      = r;
        flush      = f;
        #1;
    endtask

    initial begin
        int si;
        int ri;
        int occ_m;
        logic pop_m;
        logic xfer_m;

        rst = 1'b1; flush = 1'b0; fifo_empty = 1'b0; fifo_data = 32'hDEAD; ready = 1'b1;
        #1;
        chk("rst_occ",   32'(occupancy), 32'd0);
        chk("rst_valid", 32'(valid),     32'd0);
        chk("rst_beats", 32'(beats),     32'd0);
        chk("rst_data",  data,           32'd0);
        chk("rst_pop",   32'(fifo_pop),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        fifo_empty = 1'b1;

        // Streaming three words with ready high
        drive(1'b0, 32'hA1, 1'b1, 1'b0);
        chk("s_pop1", 32'(fifo_pop), 32'd1);
        chk("s_val0", 32'(valid),    32'd0);
        drive(1'b0, 32'hA2, 1'b1, 1'b0);
        chk("s_pop2", 32'(fifo_pop), 32'd1);
        chk("s_d1",   data,          32'hA1);
        drive(1'b0, 32'hA3, 1'b1, 1'b0);
        chk("s_pop3", 32'(fifo_pop), 32'd1);
        chk("s_d2",   data,          32'hA2);
        drive(1'b1, 32'h0, 1'b1, 1'b0);
        chk("s_pop4", 32'(fifo_pop), 32'd0);
        chk("s_d3",   data,          32'hA3);
        drive(1'b1, 32'h0, 1'b1, 1'b0);
        chk("s_beats", 32'(beats),   32'd3);
        chk("s_valid", 32'(valid),   32'd0);

        // Backpressure fills both entries and holds the head
        drive(1'b0, 32'h10, 1'b0, 1'b0);
        chk("b_pop1", 32'(fifo_pop), 32'd1);
        drive(1'b0, 32'h11, 1'b0, 1'b0);
        chk("b_pop2", 32'(fifo_pop), 32'd1);
        chk("b_occ1", 32'(occupancy), 32'd1);
        drive(1'b0, 32'h12, 1'b0, 1'b0);
        chk("b_pop3", 32'(fifo_pop), 32'd0);
        chk("b_occ2", 32'(occupancy), 32'd2);
        chk("b_hold", data,           32'h10);
        drive(1'b0, 32'h12, 1'b0, 1'b0);
        chk("b_hold2", data,          32'h10);
        chk("b_vhold", 32'(valid),    32'd1);
        drive(1'b0, 32'h12, 1'b1, 1'b0);
        chk("b_o10",  data,           32'h10);
        drive(1'b0, 32'h12, 1'b1, 1'b0);
        chk("b_o11",  data,           32'h11);
        chk("b_popr", 32'(fifo_pop),  32'd1);
        drive(1'b1, 32'h0, 1'b1, 1'b0);
        chk("b_o12",  data,           32'h12);
        drive(1'b1, 32'h0, 1'b1, 1'b0);
        chk("b_beats", 32'(beats),    32'd6);

        // 20-word stream with ready toggling, checked against an occupancy model
        si = 0; ri = 0; occ_m = 0;
        for (int c = 0; c < 100 && ri < 20; c++) begin
            drive(si >= 20, 32'h100 + 32'(si), c[0], 1'b0);
            pop_m  = (si < 20) && (occ_m < 2);
            xfer_m = (occ_m > 0) && c[0];
            chk("t_pop",   32'(fifo_pop), 32'(pop_m));
            chk("t_valid", 32'(valid),    32'(occ_m != 0));
            if (occ_m != 0) chk("t_data", data, 32'h100 + 32'(ri));
            if (pop_m)  si++;
            if (xfer_m) ri++;
            occ_m = occ_m + int'(pop_m) - int'(xfer_m);
        end
        chk("t_count", 32'(ri), 32'd20);
        drive(1'b1, 32'h0, 1'b0, 1'b0);
        chk("t_beats", 32'(beats), 32'd26);

        // Flush at occupancy 2, then flush with a concurrent transfer
        drive(1'b0, 32'h20, 1'b0, 1'b0);
        drive(1'b0, 32'h21, 1'b0, 1'b0);
        drive(1'b0, 32'h22, 1'b0, 1'b1);
        chk("f_pop",  32'(fifo_pop),  32'd0);
        chk("f_occ2", 32'(occupancy), 32'd2);
        drive(1'b1, 32'h0, 1'b0, 1'b0);
        chk("f_occ0", 32'(occupancy), 32'd0);
        chk("f_val0", 32'(valid),     32'd0);
        chk("f_beats", 32'(beats),    32'd26);
        drive(1'b0, 32'h30, 1'b0, 1'b0);
        drive(1'b0, 32'h31, 1'b1, 1'b1);
        chk("fx_pop", 32'(fifo_pop),  32'd0);
        drive(1'b1, 32'h0, 1'b0, 1'b0);
        chk("fx_beats", 32'(beats),   32'd27);
        chk("fx_occ",   32'(occupancy), 32'd0);

        // Advance the counter to 0xFFFE: 65508 streaming cycles give 65507 transfers
        for (int k = 0; k < 65508; k++) drive(1'b0, 32'(k), 1'b1, 1'b0);
        drive(1'b1, 32'h0, 1'b0, 1'b0);
        chk("w_occ", 32'(occupancy), 32'd1);
        drive(1'b0, 32'h77, 1'b1, 1'b0);
        chk("w_fffe", 32'(beats), 32'hFFFE);
        drive(1'b1, 32'h0, 1'b1, 1'b0);
        chk("w_ffff", 32'(beats), 32'hFFFF);
        drive(1'b1, 32'h0, 1'b1, 1'b0);
        chk("w_wrap", 32'(beats), 32'h0000);

        // Asynchronous reset between edges at occupancy 1
        drive(1'b0, 32'h55, 1'b0, 1'b0);
        drive(1'b1, 32'h0, 1'b0, 1'b0);
        chk("a_val1", 32'(valid),     32'd1);
        chk("a_occ1", 32'(occupancy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("a_val0",  32'(valid),     32'd0);
        chk("a_occ0",  32'(occupancy), 32'd0);
        chk("a_data0", data,           32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        drive(1'b0, 32'h66, 1'b1, 1'b0);
        chk("r_pop", 32'(fifo_pop), 32'd1);
        drive(1'b1, 32'h0, 1'b1, 1'b0);
        chk("r_data", data, 32'h66);
        drive(1'b1, 32'h0, 1'b1, 1'b0);
        chk("r_beats", 32'(beats), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
